// File: rtl/mac_seq_if.sv
// Bundle of the command, pair-stream, external-mac and result signals of mac_seq.
// The master side is the feeder/collector pair; the slave side is mac_seq itself.
interface mac_seq_if #(
  parameter int OUT_W = 16
) ();
  logic             start;
  logic [7:0]       len;
  logic [7:0]       bias;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_data;
  logic [7:0]       w_data;
  logic [7:0]       mac_in;
  logic [7:0]       mac_w;
  logic [7:0]       mac_b;
  logic [15:0]      mac_out;
  logic [OUT_W-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             busy;

  modport master (
    output start, len, bias, in_valid, in_data, w_data, mac_out, result_ready,
    input  in_ready, mac_in, mac_w, mac_b, result, result_valid, busy
  );

  modport slave (
    input  start, len, bias, in_valid, in_data, w_data, mac_out, result_ready,
    output in_ready, mac_in, mac_w, mac_b, result, result_valid, busy
  );
endinterface

// File: rtl/mac_seq.sv
// Time-multiplexes one external 8-bit mac over N pairs: result = bias + sum(in*w).
// Define MAC_SEQ_SAT_EN to saturate the result at all ones instead of truncating.
module mac_seq #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 16
) (
  input  logic     clk,
  input  logic     rst_n,
  mac_seq_if.slave bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [7:0]       len_q, len_d;
  logic [7:0]       bias_q, bias_d;
  logic [OUT_W-1:0] result_q, result_d;
  logic             in_ready_q, in_ready_d;
  logic             result_valid_q, result_valid_d;
  logic             busy_q, busy_d;
  logic             beat;

  assign beat = in_ready_q & bus.in_valid;

  // The mac sees live pair data only in RUN; bias rides on the first beat only.
  assign bus.mac_in = (state_q == RUN) ? bus.in_data : '0;
  assign bus.mac_w  = (state_q == RUN) ? bus.w_data  : '0;
  assign bus.mac_b  = (state_q == RUN && cnt_q == len_q) ? bias_q : '0;

  assign bus.in_ready     = in_ready_q;
  assign bus.result_valid = result_valid_q;
  assign bus.result       = result_q;
  assign bus.busy         = busy_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    len_d    = len_q;
    bias_d   = bias_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          len_d  = bus.len;
          bias_d = bus.bias;
          cnt_d  = bus.len;
          if (bus.len == 8'd0) begin
            acc_d   = ACC_W'(bus.bias);
            state_d = DONE;
          end else begin
            acc_d   = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (beat) begin
          acc_d = acc_q + ACC_W'(bus.mac_out);
          cnt_d = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = DONE;
        end
      end
      DONE: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Result is captured once on entry to DONE so it stays stable while held.
    if (state_d == DONE && state_q != DONE) begin
`ifdef MAC_SEQ_SAT_EN
      result_d = (|acc_d[ACC_W-1:OUT_W]) ? '1 : acc_d[OUT_W-1:0];
`else
      result_d = acc_d[OUT_W-1:0];
`endif
    end

    in_ready_d     = (state_d == RUN);
    result_valid_d = (state_d == DONE);
    busy_d         = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      acc_q          <= '0;
      cnt_q          <= '0;
      len_q          <= '0;
      bias_q         <= '0;
      result_q       <= '0;
      in_ready_q     <= 1'b0;
      result_valid_q <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      acc_q          <= acc_d;
      cnt_q          <= cnt_d;
      len_q          <= len_d;
      bias_q         <= bias_d;
      result_q       <= result_d;
      in_ready_q     <= in_ready_d;
      result_valid_q <= result_valid_d;
      busy_q         <= busy_d;
    end
  end
endmodule
